// File: rtl/sram_rd_pkg.sv
// Shared constants and FSM state type for the SRAM port-1 read streamer.
// The FLUSH state exists only when SRAM_RD_ABORT_EN is defined.
package sram_rd_pkg;

    localparam int unsigned SRAM_WORDS = 512;
    localparam int unsigned SRAM_AW    = 9;
    localparam int unsigned SRAM_DW    = 32;
    localparam int unsigned RD_LATENCY = 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
`ifdef SRAM_RD_ABORT_EN
        StDrain,
        StFlush
`else
        StDrain
`endif
    } state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous FIFO holding read words plus their last flag.
// The flush input has priority over push and pop.
module sram_rd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) count_d = count_q + CntW'(1);
            else if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sram_rd_streamer.sv
// Burst read initiator for SRAM port 1, streaming words out on valid/ready.
// Reads are only issued when the FIFO has room for every word in flight,
// so backpressure never loses data. Define SRAM_RD_ABORT_EN to add abort_i.
module sram_rd_streamer
    import sram_rd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned SRAM_AW    = 9
) (
    input  logic                 clk,
    input  logic                 rst_i,
`ifdef SRAM_RD_ABORT_EN
    input  logic                 abort_i,
`endif
    input  logic                 start_i,
    input  logic [SRAM_AW-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 csb1_o,
    output logic [SRAM_AW-1:0]   addr1_o,
    input  logic [SRAM_DW-1:0]   dout1_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [SRAM_DW-1:0]   m_data_o,
    output logic                 m_last_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] CreditLim = (CntW + 1)'(FIFO_DEPTH);

    state_e               state_q, state_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [SRAM_AW-1:0]   hold_q, hold_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 outstanding_q, outstanding_d;
    logic                 last_pend_q, last_pend_d;
    logic                 done_zero_q, done_zero_d;

    logic                 issue, drain_done, flush, push, pop, credit_ok;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [SRAM_DW:0]     fifo_rdata;

    // Words already in flight or buffered must all fit in the FIFO
    assign credit_ok = ({{CntW{1'b0}}, outstanding_q} + {1'b0, fifo_count}) < CreditLim;

    // FSM next-state, address/length counters and issue decision
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_d      = hold_q;
        rem_d       = rem_q;
        done_zero_d = 1'b0;
        issue       = 1'b0;
        drain_done  = 1'b0;
        flush       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        addr_d  = base_addr_i;
                        rem_d   = len_i;
                        state_d = StIssue;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            StIssue: begin
`ifdef SRAM_RD_ABORT_EN
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = StFlush;
                end else
`endif
                if (credit_ok) begin
                    issue  = 1'b1;
                    hold_d = addr_q;
                    addr_d = addr_q + SRAM_AW'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
`ifdef SRAM_RD_ABORT_EN
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = StFlush;
                end else
`endif
                if (!outstanding_q && fifo_empty) begin
                    drain_done = 1'b1;
                    state_d    = StIdle;
                end
            end
`ifdef SRAM_RD_ABORT_EN
            StFlush: begin
                // The read issued just before the abort lands here and is dropped
                flush      = 1'b1;
                drain_done = 1'b1;
                state_d    = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign outstanding_d = issue;
    assign last_pend_d   = issue && (rem_q == LEN_WIDTH'(1));
    assign push          = outstanding_q && !flush && !fifo_full;
    assign pop           = m_valid_o && m_ready_i;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            hold_q        <= '0;
            rem_q         <= '0;
            outstanding_q <= 1'b0;
            last_pend_q   <= 1'b0;
            done_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            hold_q        <= hold_d;
            rem_q         <= rem_d;
            outstanding_q <= outstanding_d;
            last_pend_q   <= last_pend_d;
            done_zero_q   <= done_zero_d;
        end
    end

    sram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SRAM_DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  ({last_pend_q, dout1_i}),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Address holds the last issued value while the chip select is idle
    assign csb1_o    = !issue;
    assign addr1_o   = issue ? addr_q : hold_q;
    assign m_valid_o = !fifo_empty;
    assign m_data_o  = m_valid_o ? fifo_rdata[SRAM_DW-1:0] : '0;
    assign m_last_o  = m_valid_o && fifo_rdata[SRAM_DW];
    assign done_o    = drain_done || done_zero_q;
    assign busy_o    = (state_q != StIdle) && !drain_done;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Scoreboard bench for sram_rd_streamer with a 1-cycle-latency SRAM model.
module tb_sram_rd_streamer;

    logic        clk = 1'b0;
    logic        rst_i, start_i, m_ready_i, abort_i;
    logic [8:0]  base_addr_i, addr1_o;
    logic [9:0]  len_i;
    logic        busy_o, done_o, csb1_o, m_valid_o, m_last_o;
    logic [31:0] dout1_i, m_data_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;

    logic [8:0]  exp_addr [$];
    logic [32:0] exp_data [$];
    logic [31:0] mem [512];
    logic        stall_prev = 1'b0;
    logic [32:0] stall_val;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_rd_streamer dut (
        .clk         (clk),
        .rst_i       (rst_i),
`ifdef SRAM_RD_ABORT_EN
        .abort_i     (abort_i),
`endif
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .csb1_o      (csb1_o),
        .addr1_o     (addr1_o),
        .dout1_i     (dout1_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
    );

    // SRAM port-1 model: data appears the cycle after the read
    initial for (int i = 0; i < 512; i++) mem[i] = 32'hDA7A_0000 | 32'(i);
    always @(posedge clk) if (!csb1_o) dout1_i <= mem[addr1_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks issued addresses, stream words and stall stability
    always @(negedge clk) begin
        if (!rst_i) begin
            if (!csb1_o) begin
                issue_cnt++;
                chk("issue_expected", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) chk("issue_addr", 64'(addr1_o), 64'(exp_addr.pop_front()));
            end
            if (m_valid_o && m_ready_i) begin
                last_hs_cyc = cyc;
                chk("word_expected", 64'(exp_data.size() != 0), 64'd1);
                if (exp_data.size() != 0)
                    chk("stream_word", 64'({m_last_o, m_data_o}), 64'(exp_data.pop_front()));
            end
            if (stall_prev) begin
                chk("stall_valid", 64'(m_valid_o), 64'd1);
                chk("stall_data", 64'({m_last_o, m_data_o}), 64'(stall_val));
            end
            stall_prev = m_valid_o && !m_ready_i && !abort_i;
            stall_val  = {m_last_o, m_data_o};
            if (done_o) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic expect_burst(input logic [8:0] base, input int len);
        logic [8:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 9'(i);
            exp_addr.push_back(a);
            exp_data.push_back({(i == len - 1), 32'hDA7A_0000 | 32'(a)});
        end
    endtask

    // Returns one cycle after the accepting edge
    task automatic start_burst(input logic [8:0] base, input logic [9:0] len);
        @(posedge clk); #1;
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (done_o) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) chk({nm, "_busy_at_done"}, 64'(busy_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_csb1"}, 64'(csb1_o), 64'd1);
        chk({nm, "_addr1"}, 64'(addr1_o), 64'd0);
        chk({nm, "_valid"}, 64'(m_valid_o), 64'd0);
        chk({nm, "_data"}, 64'(m_data_o), 64'd0);
        chk({nm, "_last"}, 64'(m_last_o), 64'd0);
        chk({nm, "_busy"}, 64'(busy_o), 64'd0);
        chk({nm, "_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ic0, dc0, n;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        m_ready_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic burst: issue timing, first-valid latency, last flag, done timing
        m_ready_i = 1'b1;
        expect_burst(9'h010, 4);
        start_burst(9'h010, 10'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_issue_consecutive", 64'(csb1_o), 64'd0);
            if (k == 0) chk("t1_busy", 64'(busy_o), 64'd1);
            if (k < 2) chk("t1_valid_early", 64'(m_valid_o), 64'd0);
            if (k == 2) chk("t1_first_valid", 64'(m_valid_o), 64'd1);
        end
        wait_done("t1");
        chk("t1_done_after_last_hs", 64'(cyc - last_hs_cyc), 64'd1);
        @(negedge clk);
        chk("t1_done_single_pulse", 64'(done_o), 64'd0);
        chk("t1_addr_hold", 64'(addr1_o), 64'h013);
        chk("t1_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);

        // Address wrap-around
        expect_burst(9'h1FE, 4);
        start_burst(9'h1FE, 10'd4);
        wait_done("wrap");
        chk("wrap_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);

        // Backpressure: issues stall at FIFO depth
        m_ready_i = 1'b0;
        @(posedge clk); #1;
        ic0 = issue_cnt;
        expect_burst(9'h100, 16);
        start_burst(9'h100, 10'd16);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        chk("bp_issue_stall", 64'(issue_cnt - ic0), 64'd4);
        chk("bp_valid_held", 64'(m_valid_o), 64'd1);
        m_ready_i = 1'b1;
        wait_done("bp");
        chk("bp_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);
        @(posedge clk); #1;
        chk("bp_issue_total", 64'(issue_cnt - ic0), 64'd16);

        // Zero length: done next cycle, no reads
        ic0 = issue_cnt;
        start_burst(9'h055, 10'd0);
        @(negedge clk);
        chk("len0_done", 64'(done_o), 64'd1);
        chk("len0_csb1", 64'(csb1_o), 64'd1);
        chk("len0_valid", 64'(m_valid_o), 64'd0);
        chk("len0_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("len0_done_pulse", 64'(done_o), 64'd0);
        repeat (3) @(posedge clk); #1;
        chk("len0_no_issue", 64'(issue_cnt - ic0), 64'd0);

        // Start while busy is ignored
        ic0 = issue_cnt;
        dc0 = done_cnt;
        expect_burst(9'h040, 4);
        start_burst(9'h040, 10'd4);
        base_addr_i = 9'h0F0;
        len_i       = 10'd4;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
        wait_done("busy_start");
        repeat (6) @(posedge clk); #1;
        chk("busy_start_issues", 64'(issue_cnt - ic0), 64'd4);
        chk("busy_start_dones", 64'(done_cnt - dc0), 64'd1);
        chk("busy_start_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);

        // Reset mid-burst, then a fresh burst
        expect_burst(9'h080, 16);
        start_burst(9'h080, 10'd16);
        repeat (4) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        expect_burst(9'h020, 3);
        start_burst(9'h020, 10'd3);
        wait_done("post_rst");
        chk("post_rst_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);

`ifdef SRAM_RD_ABORT_EN
        // Abort after three issues with the consumer stalled
        m_ready_i = 1'b0;
        @(posedge clk); #1;
        ic0 = issue_cnt;
        dc0 = done_cnt;
        exp_addr.push_back(9'h030);
        exp_addr.push_back(9'h031);
        exp_addr.push_back(9'h032);
        start_burst(9'h030, 10'd10);
        n = 0;
        while ((issue_cnt - ic0) < 3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_word3", 64'(issue_cnt - ic0), 64'd3);
        abort_i = 1'b1;
        @(negedge clk);
        chk("abort_no_issue", 64'(csb1_o), 64'd1);
        chk("abort_no_last", 64'(m_last_o), 64'd0);
        @(posedge clk); #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk("abort_valid_low", 64'(m_valid_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd1);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_last_low", 64'(m_last_o), 64'd0);
        m_ready_i = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("abort_issue_total", 64'(issue_cnt - ic0), 64'd3);
        chk("abort_dones", 64'(done_cnt - dc0), 64'd1);
        chk("abort_valid_idle", 64'(m_valid_o), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Initiator for the read-only port (port 1) of the 2 KB sky130 SRAM macro (32 x 512, 1rw1r). On a start pulse it issues a burst of sequential word reads and returns the data on a valid/ready stream. A credit-limited output FIFO absorbs the macro's fixed read latency, so backpressure never drops data. It sits between the SRAM macro's port 1 and any streaming consumer, such as a DMA or a peripheral TX path, while port 0 remains owned by the CPU-side RAM wrapper.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- LEN_WIDTH, 10: width of the burst length field; maximum burst is 2^LEN_WIDTH-1 words.
- SRAM_AW, 9: SRAM word-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  single-cycle burst request; sampled only in IDLE.
- base_addr_i  in  SRAM_AW  first word address; latched at start.
- len_i  in  LEN_WIDTH  number of words to read; latched at start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  single-cycle pulse at burst completion.
- csb1_o  out  1  SRAM port-1 chip select, active-low.
- addr1_o  out  SRAM_AW  SRAM port-1 word address.
- dout1_i  in  32  SRAM port-1 read data.
- m_valid_o  out  1  stream data valid.
- m_ready_i  in  1  stream consumer ready.
- m_data_o  out  32  stream data.
- m_last_o  out  1  high with the final word of the burst.
- abort_i  in  1  present only with SRAM_RD_ABORT_EN.

## Operation
- FSM states are IDLE, ISSUE and DRAIN, plus FLUSH when aborts are compiled in.
- IDLE:
  - start_i with len_i != 0: latch base_addr_i and len_i, then go to ISSUE.
  - start_i with len_i == 0: pulse done_o on the next cycle, issue no reads, stay in IDLE.
- ISSUE: each cycle, a read is issued (csb1_o=0, addr1_o=current address) only if outstanding_reads + fifo_count < FIFO_DEPTH.
  - On each issue, the current address increments modulo 2^SRAM_AW (511 wraps to 0) and the issued count increments.
  - After the len-th issue, go to DRAIN.
- DRAIN: when no reads are outstanding, the FIFO is empty and the last handshake has occurred, pulse done_o and return to IDLE.
- Read data from dout1_i is written into the FIFO exactly RD_LATENCY=1 cycle after its issue cycle, together with a last flag set for the len-th word.
- Stream rules:
  - Transfer occurs when m_valid_o && m_ready_i.
  - m_data_o and m_last_o are stable while m_valid_o && !m_ready_i.
  - A FIFO write and read in the same cycle leave the count unchanged.
- start_i while busy_o=1 is ignored, with no queuing.
- Outstanding-read counter: 0..1, incremented on issue and decremented on capture; a simultaneous issue and capture leaves it unchanged.
- When csb1_o=1, addr1_o holds its last value.

## Timing
- Reset values: csb1_o=1, addr1_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, done_o=0, FIFO empty, FSM in IDLE.
- Start accepted at edge E; the first issue (csb1_o=0) is in the cycle after E.
- First m_valid_o is two cycles after the first issue: one cycle of SRAM latency, then one cycle for the FIFO write.
- With m_ready_i held high, throughput is one word per cycle after fill.
- done_o pulses in the cycle after the last handshake; busy_o drops in that same cycle.
- rst_i during a burst returns every output to its reset value on the next edge; data in flight is discarded.

## Configuration
- SRAM_RD_ABORT_EN defined:
  - abort_i exists. When asserted in ISSUE or DRAIN, issuing stops immediately.
  - The FSM enters FLUSH for one cycle so the in-flight read lands and is dropped.
  - The FIFO is cleared and m_valid_o goes low in the cycle after abort.
  - done_o pulses as FLUSH exits to IDLE; m_last_o is never asserted for an aborted burst.
  - abort_i in IDLE has no effect.
- SRAM_RD_ABORT_EN undefined: no abort_i port, no FLUSH state; every burst runs to completion.

## Structure
- Package sram_rd_pkg holds:
  - SRAM_WORDS=512, SRAM_AW=9 and SRAM_DW=32;
  - RD_LATENCY=1;
  - the FSM state enum.
- Sub-module sram_rd_fifo provides a synchronous FIFO of width SRAM_DW+1 (data plus last) and depth FIFO_DEPTH.
  - Ports: push, pop, flush, count, full and empty.
  - Ordering: flush has priority over push and pop.
- The top level contains the FSM, address and length counters, the credit check, and the SRAM port-1 drive.

## Test plan
- Reset, then start with base=0x010, len=4, m_ready_i=1:
  - addr1_o sequence is 0x010..0x013 on consecutive cycles;
  - the stream returns the preloaded words in order;
  - m_last_o is set on word 4 only, followed by a single done_o pulse.
- Wrap-around: base=0x1FE, len=4 → addresses 0x1FE, 0x1FF, 0x000, 0x001; data matches.
- Backpressure: len=16, m_ready_i=0 for 20 cycles, then 1:
  - issues stall at FIFO_DEPTH words, with no data loss or duplication;
  - all 16 words arrive in order and m_data_o is stable while stalled.
- len=0 → done_o pulses one cycle after start, csb1_o stays 1 and m_valid_o stays 0. A second start_i pulse during a busy burst is ignored, with no extra reads.
- Synchronous rst_i asserted mid-burst → all outputs at reset values on the next edge; a new burst afterwards completes normally.
- With SRAM_RD_ABORT_EN: abort_i at word 3 of len=10 → no further issues, m_valid_o low the next cycle, done_o pulses, m_last_o never seen.
